// File: rtl/etapa7_if.sv
// Bus between the quotient sign-correction stage, the final divider stage and
// the result consumer. The slave modport is the view that etapa7 itself uses.
interface etapa7_if #(
  parameter int AnchoDv  = 15,
  parameter int AnchoDd  = 31,
  parameter int AnchoQ   = 15,
  parameter int AnchoPtr = 2
);
  logic              goIn;
  logic [AnchoDv:0]  divisorIn;
  logic [AnchoDd:0]  dividendIn;
  logic [AnchoQ:0]   quotientIn;
  logic              negDivisorIn;
  logic              negDividendIn;
  logic              DivisorNoCeroIn;
  logic              readyIn;
  logic              clrOverflow;
  logic              validOut;
  logic [AnchoQ:0]   quotientOut;
  logic [AnchoQ:0]   remainderOut;
  logic              divCeroOut;
  logic              overflowOut;
  logic [AnchoPtr:0] countOut;

  modport master (
    output goIn, divisorIn, dividendIn, quotientIn, negDivisorIn, negDividendIn,
           DivisorNoCeroIn, readyIn, clrOverflow,
    input  validOut, quotientOut, remainderOut, divCeroOut, overflowOut, countOut
  );

  modport slave (
    input  goIn, divisorIn, dividendIn, quotientIn, negDivisorIn, negDividendIn,
           DivisorNoCeroIn, readyIn, clrOverflow,
    output validOut, quotientOut, remainderOut, divCeroOut, overflowOut, countOut
  );
endinterface

// File: rtl/etapa7.sv
// Final divider stage: extracts and sign-corrects the remainder, flags a zero
// divisor and buffers finished results in a small FIFO, since the pipeline cannot stall.
module etapa7 #(
  parameter int AnchoDv  = 15,
  parameter int AnchoDd  = 31,
  parameter int AnchoQ   = 15,
  parameter int SupDvMn  = 16,
  parameter int Prof     = 4,
  parameter int AnchoPtr = 2
) (
  input logic   clk,
  input logic   reset,
  etapa7_if.slave bus
);
  // Handshake: a head entry moves to the consumer at a rising edge where
  // validOut and readyIn are both high; validOut never depends on readyIn.
  localparam logic [AnchoPtr:0] ProfCnt = (AnchoPtr + 1)'(Prof);

  logic [AnchoQ:0]   qMem [Prof];
  logic [AnchoQ:0]   rMem [Prof];
  logic [Prof-1:0]   dcMem;
  logic [AnchoPtr-1:0] wrPtr;
  logic [AnchoPtr-1:0] rdPtr;
  logic [AnchoPtr:0] count;
  logic              overflow;

  logic [AnchoQ:0] remMag;
  logic [AnchoQ:0] remSigned;
  logic [AnchoQ:0] entryQ;
  logic [AnchoQ:0] entryR;
  logic            entryDc;
  logic            full;
  logic            push;
  logic            pop;
  logic            doWrite;
  logic            drop;

  // The divisor, its sign and the low dividend field carry no information here.
  logic unusedBits;
  assign unusedBits = &{1'b0, bus.divisorIn, bus.negDivisorIn, bus.dividendIn[SupDvMn-1:0]};

  assign remMag    = (AnchoQ + 1)'(bus.dividendIn[AnchoDd:SupDvMn]);
  assign remSigned = bus.negDividendIn ? (~remMag + 1'b1) : remMag;

  always_comb begin
    entryQ  = bus.quotientIn;
    entryR  = remSigned;
    entryDc = 1'b0;
    if (!bus.DivisorNoCeroIn) begin
      entryQ  = '1;
      entryR  = '0;
      entryDc = 1'b1;
    end
  end

  assign full    = (count == ProfCnt);
  assign push    = bus.goIn;
  assign pop     = bus.validOut & bus.readyIn;
  // When full, a simultaneous pop frees the very slot the write lands in.
  assign doWrite = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dcMem    <= '0;
      for (int i = 0; i < Prof; i++) begin
        qMem[i] <= '0;
        rMem[i] <= '0;
      end
    end else begin
      if (doWrite) begin
        qMem[wrPtr]  <= entryQ;
        rMem[wrPtr]  <= entryR;
        dcMem[wrPtr] <= entryDc;
        wrPtr        <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (doWrite && !pop) begin
        count <= count + 1'b1;
      end else if (!doWrite && pop) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (bus.clrOverflow) begin
        overflow <= 1'b0;
      end
    end
  end

  assign bus.validOut     = (count != '0);
  assign bus.quotientOut  = qMem[rdPtr];
  assign bus.remainderOut = rMem[rdPtr];
  assign bus.divCeroOut   = dcMem[rdPtr];
  assign bus.overflowOut  = overflow;
  assign bus.countOut     = count;
endmodule

// File: tb/tb_etapa7.sv
// Bench for etapa7: directed cases plus random traffic against a queue-based
// reference; a predictor fills the expected queue, a monitor pops and compares.
module tb_etapa7;
  localparam int Prof = 4;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dc;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  entry_t expQ[$];
  logic modelOvf = 1'b0;
  int total = 0;
  int bad = 0;

  etapa7_if #(.AnchoDv(15), .AnchoDd(31), .AnchoQ(15), .AnchoPtr(2)) bus ();

  etapa7 #(.AnchoDv(15), .AnchoDd(31), .AnchoQ(15), .SupDvMn(16), .Prof(Prof), .AnchoPtr(2))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Reference: remainder is the upper dividend half, negated when the dividend was negative.
  function automatic entry_t refEntry(input logic [31:0] dvd, input logic [15:0] q,
                                      input logic negDd, input logic nz);
    entry_t e;
    int unsigned mag;
    mag = dvd / 65536;
    if (!nz) begin
      e.q = 16'hFFFF;
      e.r = 16'h0000;
      e.dc = 1'b1;
    end else begin
      e.q = q;
      e.r = negDd ? 16'((65536 - mag) % 65536) : 16'(mag);
      e.dc = 1'b0;
    end
    return e;
  endfunction

  // Predictor: inputs are stable at the rising edge; the monitor has already
  // removed the entry being popped at this edge, so size==Prof means a drop.
  always @(posedge clk) begin
    if (!reset) begin
      if (bus.goIn && expQ.size() == Prof) begin
        modelOvf = 1'b1;
      end else begin
        if (bus.goIn)
          expQ.push_back(refEntry(bus.dividendIn, bus.quotientIn, bus.negDividendIn,
                                  bus.DivisorNoCeroIn));
        if (bus.clrOverflow) modelOvf = 1'b0;
      end
    end
  end

  // Monitor: compare outputs mid-cycle, then retire the head if it pops at the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("countOut", 32'(bus.countOut), 32'(expQ.size()));
      check("validOut", 32'(bus.validOut), 32'(expQ.size() != 0));
      check("overflowOut", 32'(bus.overflowOut), 32'(modelOvf));
      if (expQ.size() != 0) begin
        check("quotientOut", 32'(bus.quotientOut), 32'(expQ[0].q));
        check("remainderOut", 32'(bus.remainderOut), 32'(expQ[0].r));
        check("divCeroOut", 32'(bus.divCeroOut), 32'(expQ[0].dc));
        if (bus.readyIn) void'(expQ.pop_front());
      end
    end
  end

  task automatic drive(input logic go, input logic [15:0] q, input logic [15:0] hi,
                       input logic negDd, input logic nz, input logic rdy, input logic clr);
    bus.goIn = go;
    bus.quotientIn = q;
    bus.dividendIn = {hi, 16'($urandom)};
    bus.divisorIn = 16'($urandom);
    bus.negDivisorIn = 1'($urandom);
    bus.negDividendIn = negDd;
    bus.DivisorNoCeroIn = nz;
    bus.readyIn = rdy;
    bus.clrOverflow = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && expQ.size() != 0; i++) idle(1'b1);
    check("drainTimeout", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    bus.goIn = 1'b0; bus.quotientIn = '0; bus.dividendIn = '0; bus.divisorIn = '0;
    bus.negDivisorIn = 1'b0; bus.negDividendIn = 1'b0; bus.DivisorNoCeroIn = 1'b1;
    bus.readyIn = 1'b0; bus.clrOverflow = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rstCount", 32'(bus.countOut), 32'd0);
    check("rstValid", 32'(bus.validOut), 32'd0);
    check("rstQuot", 32'(bus.quotientOut), 32'd0);
    check("rstRem", 32'(bus.remainderOut), 32'd0);
    check("rstDivCero", 32'(bus.divCeroOut), 32'd0);
    check("rstOvf", 32'(bus.overflowOut), 32'd0);
    #1;

    // -7/2, 100/7 and a zero divisor, each consumed immediately.
    drive(1'b1, 16'hFFFD, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    drive(1'b1, 16'd14, 16'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    drive(1'b1, 16'h1234, 16'h0055, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("zeroDivQuot", 32'(bus.quotientOut), 32'h0000FFFF);
    check("zeroDivFlag", 32'(bus.divCeroOut), 32'd1);
    idle(1'b1);

    // Backpressure: five results into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) drive(1'b1, 16'(i), 16'(i * 3), 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check("bpCount", 32'(bus.countOut), 32'd4);
    check("bpOvf", 32'(bus.overflowOut), 32'd1);
    #1;
    drain();
    #1;
    check("ovfSticky", 32'(bus.overflowOut), 32'd1);
    #1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    check("ovfCleared", 32'(bus.overflowOut), 32'd0);
    #1;

    // Full FIFO with a simultaneous push and pop.
    for (int i = 11; i <= 14; i++) drive(1'b1, 16'(i), 16'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'd9, 16'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    check("fullPpCount", 32'(bus.countOut), 32'd4);
    check("fullPpOvf", 32'(bus.overflowOut), 32'd0);
    #1;
    drain();

    // Asynchronous reset between edges with three entries held.
    for (int i = 0; i < 3; i++) drive(1'b1, 16'(20 + i), 16'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check("asyncCount", 32'(bus.countOut), 32'd0);
    check("asyncValid", 32'(bus.validOut), 32'd0);
    expQ.delete();
    modelOvf = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Random traffic with occasional zero divisors and overflow clears.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
            1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
